// File: rtl/sdram_burst_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdram_burst_responder: Avalon-MM burst slave backed by on-chip RAM with    |
// | deterministic command stalls, fixed read latency and sticky proto flag.    |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module sdram_burst_responder #(
  parameter int ADDR_WIDTH   = 29,
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_WIDTH  = 8,
  parameter int MEM_AW       = 10,
  parameter int READ_LATENCY = 2,
  parameter int CMD_WAIT     = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [BURST_WIDTH-1:0]    burstcount,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     writedata,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  output logic                      waitrequest,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      readdatavalid,
  output logic                      busy,
  output logic                      proto_error
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << MEM_AW;
  localparam int WAIT_W = (CMD_WAIT > 0) ? $clog2(CMD_WAIT + 1) : 1;
  localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [WAIT_W-1:0]      WAIT_LIMIT = WAIT_W'(CMD_WAIT);
  localparam logic [WAIT_W-1:0]      WAIT_ONE   = WAIT_W'(1);
  localparam logic [LAT_W-1:0]       LAT_LAST   = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0]       LAT_ONE    = LAT_W'(1);
  localparam logic [BURST_WIDTH-1:0] BEAT_ONE   = BURST_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITE_BURST = 2'd1,
    READ_WAIT   = 2'd2,
    READ_BURST  = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                 state_q,    state_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [BURST_WIDTH-1:0] beat_q,     beat_d;
  logic [BURST_WIDTH-1:0] len_q,      len_d;
  logic [MEM_AW-1:0]      base_q,     base_d;
  logic [LAT_W-1:0]       lat_q,      lat_d;
  logic [DATA_WIDTH-1:0]  readdata_q, readdata_d;
  logic                   rdv_q,      rdv_d;
  logic                   perr_q,     perr_d;

  logic                   w_cmd;
  logic                   w_hold;
  logic                   w_accept;
  logic [BURST_WIDTH-1:0] w_len;
  logic [MEM_AW-1:0]      w_beat_idx;
  logic [MEM_AW-1:0]      w_mem_widx;
  logic                   w_mem_we;
  logic [DATA_WIDTH-1:0]  w_mem_rdata;

  generate
    if (ADDR_WIDTH > MEM_AW) begin : g_addr_upper
      // Upper address bits alias onto the RAM, so they are deliberately dropped.
      logic unused_addr_upper;
      assign unused_addr_upper = ^address[ADDR_WIDTH-1:MEM_AW];
    end
  endgenerate

  assign w_cmd      = read | write;
  assign w_hold     = w_cmd && (wait_cnt_q != WAIT_LIMIT);
  assign w_len      = (burstcount == '0) ? BEAT_ONE : burstcount;
  assign w_beat_idx = base_q + MEM_AW'(beat_q);

  always_comb begin
    waitrequest = 1'b1;
    if (reset_n) begin
      case (state_q)
        IDLE:        waitrequest = w_hold;
        WRITE_BURST: waitrequest = 1'b0;
        default:     waitrequest = 1'b1;
      endcase
    end
  end

  assign w_accept    = (state_q == IDLE) && w_cmd && !waitrequest;
  assign w_mem_we    = (state_q == IDLE) ? (w_accept && write)
                                         : ((state_q == WRITE_BURST) && write);
  assign w_mem_widx  = (state_q == IDLE) ? address[MEM_AW-1:0] : w_beat_idx;
  assign w_mem_rdata = mem[w_beat_idx];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    beat_d     = beat_q;
    len_d      = len_q;
    base_d     = base_q;
    lat_d      = lat_q;
    readdata_d = readdata_q;
    rdv_d      = 1'b0;
    perr_d     = perr_q;
    case (state_q)
      IDLE: begin
        if (w_hold) wait_cnt_d = wait_cnt_q + WAIT_ONE;
        if (w_accept) begin
          base_d = address[MEM_AW-1:0];
          len_d  = w_len;
          if (burstcount == '0) perr_d = 1'b1;
          if (read && write)    perr_d = 1'b1;
          if (write) begin
            // First beat lands at the accepting edge; single-beat writes stay in IDLE.
            beat_d = BEAT_ONE;
            if (w_len != BEAT_ONE) state_d = WRITE_BURST;
          end else begin
            beat_d  = '0;
            lat_d   = '0;
            state_d = READ_WAIT;
          end
        end
      end
      WRITE_BURST: begin
        if (read) perr_d = 1'b1;
        if (write) begin
          beat_d = beat_q + BEAT_ONE;
          if (beat_q + BEAT_ONE == len_q) state_d = IDLE;
        end
      end
      READ_WAIT: begin
        if (write) perr_d = 1'b1;
        if (lat_q == LAT_LAST) begin
          readdata_d = w_mem_rdata;
          rdv_d      = 1'b1;
          beat_d     = BEAT_ONE;
          state_d    = READ_BURST;
        end else begin
          lat_d = lat_q + LAT_ONE;
        end
      end
      READ_BURST: begin
        if (beat_q == len_q) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          readdata_d = w_mem_rdata;
          rdv_d      = 1'b1;
          beat_d     = beat_q + BEAT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      beat_q     <= '0;
      len_q      <= '0;
      base_q     <= '0;
      lat_q      <= '0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      base_q     <= base_d;
      lat_q      <= lat_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
      perr_q     <= perr_d;
    end
  end

  // Backing RAM keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byteenable[b]) mem[w_mem_widx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;
  assign busy          = (state_q != IDLE);
  assign proto_error   = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sdram_burst_responder: directed + randomized bench with a word-array    |
// | memory model for sdram_burst_responder.  Revision: 1.0                     |
// +--------------------------------------------------------------------------+
module tb_sdram_burst_responder;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [28:0] address = '0;
  logic [7:0]  burstcount = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [63:0] writedata = '0;
  logic [7:0]  byteenable = '0;
  logic        waitrequest, readdatavalid, busy, proto_error;
  logic [63:0] readdata;

  logic [28:0] w1_address = '0;
  logic [7:0]  w1_burstcount = '0;
  logic        w1_read = 1'b0, w1_write = 1'b0;
  logic [63:0] w1_writedata = '0;
  logic [7:0]  w1_byteenable = '0;
  logic        w1_waitrequest, w1_readdatavalid, w1_busy, w1_proto_error;
  logic [63:0] w1_readdata;

  logic [63:0] model [1024];
  logic [63:0] wd_q [$];
  logic [7:0]  be_q [$];
  int          n_assert = 0;
  int          n_fail = 0;
  bit          perr_exp = 1'b0;

  always #5 clk = ~clk;

  sdram_burst_responder #(
    .ADDR_WIDTH(29), .DATA_WIDTH(64), .BURST_WIDTH(8),
    .MEM_AW(10), .READ_LATENCY(RL), .CMD_WAIT(0)
  ) u_dut (
    .clock(clk), .reset_n(rst_n), .address(address), .burstcount(burstcount),
    .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .busy(busy), .proto_error(proto_error)
  );

  sdram_burst_responder #(
    .ADDR_WIDTH(29), .DATA_WIDTH(64), .BURST_WIDTH(8),
    .MEM_AW(10), .READ_LATENCY(RL), .CMD_WAIT(3)
  ) u_dut_wait (
    .clock(clk), .reset_n(rst_n), .address(w1_address), .burstcount(w1_burstcount),
    .read(w1_read), .write(w1_write), .writedata(w1_writedata), .byteenable(w1_byteenable),
    .waitrequest(w1_waitrequest), .readdata(w1_readdata), .readdatavalid(w1_readdatavalid),
    .busy(w1_busy), .proto_error(w1_proto_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call right after driving at a negedge; returns with the accepting posedge next.
  task automatic wait_accept(input string tag);
    int guard;
    guard = 0;
    #1;
    while (waitrequest !== 1'b0 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check(tag, waitrequest, 64'd0);
  endtask

  task automatic model_write(input logic [28:0] addr, input int k,
                             input logic [63:0] d, input logic [7:0] be);
    int idx;
    idx = (int'(addr) + k) % 1024;
    for (int b = 0; b < 8; b++)
      if (be[b]) model[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic fill(input int n, input bit rand_be);
    wd_q.delete();
    be_q.delete();
    for (int i = 0; i < n; i++) begin
      wd_q.push_back({$urandom, $urandom});
      be_q.push_back(rand_be ? 8'($urandom) : 8'hFF);
    end
  endtask

  task automatic wr_burst(input logic [28:0] addr, input logic [7:0] bc,
                          input bit with_read, input bit gaps);
    int n;
    n = (bc == 0) ? 1 : int'(bc);
    @(negedge clk);
    address = addr; burstcount = bc; write = 1'b1; read = with_read;
    writedata = wd_q[0]; byteenable = be_q[0];
    wait_accept("wr_accept");
    model_write(addr, 0, wd_q[0], be_q[0]);
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      read = 1'b0;
      if (gaps && $urandom_range(2) == 0) begin
        write = 1'b0; writedata = {$urandom, $urandom}; byteenable = 8'hFF;
        @(negedge clk);
      end
      check("wr_busy", busy, 64'd1);
      address = 29'($urandom); burstcount = 8'($urandom);
      write = 1'b1; writedata = wd_q[k]; byteenable = be_q[k];
      wait_accept("wr_beat");
      model_write(addr, k, wd_q[k], be_q[k]);
    end
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    check("wr_done_busy", busy, 64'd0);
  endtask

  // j counts posedges since the accepting edge; beat k is visible at j = RL + k.
  task automatic rd_burst(input logic [28:0] addr, input logic [7:0] bc);
    int n, base;
    n = (bc == 0) ? 1 : int'(bc);
    base = int'(addr) % 1024;
    @(negedge clk);
    address = addr; burstcount = bc; read = 1'b1; write = 1'b0;
    wait_accept("rd_accept");
    for (int j = 0; j <= RL + n; j++) begin
      @(negedge clk);
      if (j < RL) begin
        check("rd_latency_valid", readdatavalid, 64'd0);
        check("rd_latency_busy", busy, 64'd1);
      end else if (j < RL + n) begin
        check("rd_valid", readdatavalid, 64'd1);
        check("rd_data", readdata, model[(base + j - RL) % 1024]);
        check("rd_wait", waitrequest, 64'd1);
      end else begin
        check("rd_end_valid", readdatavalid, 64'd0);
        check("rd_end_wait", waitrequest, 64'd0);
        check("rd_hold", readdata, model[(base + n - 1) % 1024]);
        check("rd_end_busy", busy, 64'd0);
        check("rd_perr", proto_error, 64'(perr_exp));
      end
      if (j == 0) begin
        read = 1'b0; address = 29'($urandom); burstcount = 8'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; read = 1'b1; write = 1'b0;
    #1;
    check("rst_wait", waitrequest, 64'd1);
    check("rst_valid", readdatavalid, 64'd0);
    check("rst_rdata", readdata, 64'd0);
    check("rst_busy", busy, 64'd0);
    check("rst_perr", proto_error, 64'd0);
    @(negedge clk);
    read = 1'b0; rst_n = 1'b1; perr_exp = 1'b0;
    #1;
    check("rst_idle_wait", waitrequest, 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [28:0] a;
    logic [63:0] d;

    do_reset();

    for (int blk = 0; blk < 8; blk++) begin
      fill(128, 1'b0);
      wr_burst(29'(blk * 128), 8'd128, 1'b0, 1'b0);
    end

    wd_q = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    be_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wr_burst(29'h10, 8'd4, 1'b0, 1'b0);
    rd_burst(29'h10, 8'd4);

    wd_q = '{64'h1111111111111111}; be_q = '{8'hFF};
    wr_burst(29'h20, 8'd1, 1'b0, 1'b0);
    wd_q = '{64'hFFFFFFFFFFFFFFFF}; be_q = '{8'h0F};
    wr_burst(29'h20, 8'd1, 1'b0, 1'b0);
    rd_burst(29'h20, 8'd1);

    wd_q = '{64'd1, 64'd2, 64'd3}; be_q = '{8'hFF, 8'hFF, 8'hFF};
    wr_burst(29'h3FF, 8'd3, 1'b0, 1'b0);
    rd_burst(29'h3FF, 8'd3);
    rd_burst(29'h0ABC0000, 8'd1);
    rd_burst(29'h15550001, 8'd1);

    // Command stall on the CMD_WAIT=3 instance
    d = {$urandom, $urandom};
    @(negedge clk);
    w1_address = 29'h0; w1_burstcount = 8'd1; w1_write = 1'b1;
    w1_writedata = d; w1_byteenable = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cw_wr_wait", w1_waitrequest, 64'(i < 3));
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    w1_write = 1'b0; w1_writedata = '0;
    w1_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cw_rd_wait", w1_waitrequest, 64'(i < 3));
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    w1_read = 1'b0;
    repeat (RL) @(negedge clk);
    check("cw_rd_valid", w1_readdatavalid, 64'd1);
    check("cw_rd_data", w1_readdata, d);

    for (int op = 0; op < 24; op++) begin
      n = $urandom_range(8, 1);
      a = 29'($urandom);
      if ($urandom_range(1) == 1) begin
        fill(n, 1'b1);
        wr_burst(a, 8'(n), 1'b0, 1'b1);
      end else begin
        rd_burst(a, 8'(n));
      end
    end

    do_reset();
    fill(1, 1'b0);
    wr_burst(29'h40, 8'd1, 1'b1, 1'b0);
    perr_exp = 1'b1;
    rd_burst(29'h40, 8'd1);
    rd_burst(29'h10, 8'd2);

    do_reset();
    fill(1, 1'b0);
    wr_burst(29'h50, 8'd0, 1'b0, 1'b0);
    perr_exp = 1'b1;
    rd_burst(29'h50, 8'd0);

    do_reset();
    @(negedge clk);
    address = 29'h10; burstcount = 8'd8; read = 1'b1;
    wait_accept("mr_accept");
    for (int j = 0; j <= RL + 2; j++) begin
      @(negedge clk);
      if (j == 0) read = 1'b0;
    end
    check("mr_beat2_valid", readdatavalid, 64'd1);
    check("mr_beat2_data", readdata, model[18]);
    rst_n = 1'b0;
    #1;
    check("mr_rst_valid", readdatavalid, 64'd0);
    check("mr_rst_wait", waitrequest, 64'd1);
    check("mr_rst_busy", busy, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_idle_wait", waitrequest, 64'd0);
    check("mr_idle_busy", busy, 64'd0);
    check("mr_idle_valid", readdatavalid, 64'd0);
    rd_burst(29'h10, 8'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
